// File: rtl/imem_fetch_arbiter_if.sv
// Requester-side bundle of the instruction-memory fetch arbiter: IF and DBG request/grant
// handshakes plus the shared read-return word.
interface imem_fetch_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] rdata;
  logic        rerr;

  // Requesters drive req/addr and observe grants and returned data.
  modport master (
    output if_req, if_addr, dbg_req, dbg_addr,
    input  if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, rdata, rerr
  );

  // The arbiter consumes requests and produces grants and returned data.
  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr,
    output if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, rdata, rerr
  );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares a byte-wide synchronous instruction-memory read port between instruction fetch (IF)
// and the debug/loader port (DBG). Each grant reads four consecutive bytes (wrapping at the
// top of memory) and returns them as one big-endian word; out-of-range requests return an
// error without touching memory.
module imem_fetch_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  imem_fetch_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic                 mem_rd_en_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic [7:0]           mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StRd2, StRd3, StLast, StOor} state_e;

  state_e        state_q;
  logic          last_dbg_q;   // requester granted most recently (1 = DBG)
  logic          owner_dbg_q;  // requester owning the in-flight word (1 = DBG)
  logic [23:0]   asm_q;        // bytes 0..2 collected so far, byte 0 ends up in the top
  logic [31:0]   rdata_q;
  logic          rerr_q;
  logic          if_rvalid_q;
  logic          dbg_rvalid_q;
  logic          mem_rd_en_q;
  logic [AW-1:0] mem_addr_q;

  logic          idle;
  logic          pick_if;
  logic [31:0]   sel_addr;

  // Grants are only offered from IDLE and are suppressed while reset is held.
  assign idle     = (state_q == StIdle) && rst_ni;
  // IF wins when alone or when both ask and DBG was served last.
  assign pick_if  = bus.if_req && (!bus.dbg_req || last_dbg_q);
  assign sel_addr = pick_if ? bus.if_addr : bus.dbg_addr;

  assign bus.if_gnt     = idle && pick_if;
  assign bus.dbg_gnt    = idle && bus.dbg_req && !pick_if;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.rerr       = rerr_q;
  assign busy_o         = (state_q != StIdle);
  assign mem_rd_en_o    = mem_rd_en_q;
  assign mem_addr_o     = mem_addr_q;

  // Arbitration, byte sequencing and word return FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_dbg_q   <= 1'b1;
      owner_dbg_q  <= 1'b0;
      asm_q        <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.if_gnt || bus.dbg_gnt) begin
            owner_dbg_q <= !pick_if;
            last_dbg_q  <= !pick_if;
            if (sel_addr < 32'(MEM_BYTES)) begin
              state_q     <= StRd0;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= sel_addr[AW-1:0];
            end else begin
              state_q <= StOor;
            end
          end
        end
        StRd0: begin
          mem_addr_q <= mem_addr_q + AW'(1);
          state_q    <= StRd1;
        end
        StRd1: begin
          asm_q      <= {asm_q[15:0], mem_rdata_i};
          mem_addr_q <= mem_addr_q + AW'(1);
          state_q    <= StRd2;
        end
        StRd2: begin
          asm_q      <= {asm_q[15:0], mem_rdata_i};
          mem_addr_q <= mem_addr_q + AW'(1);
          state_q    <= StRd3;
        end
        StRd3: begin
          asm_q       <= {asm_q[15:0], mem_rdata_i};
          mem_rd_en_q <= 1'b0;
          state_q     <= StLast;
        end
        StLast: begin
          rdata_q      <= {asm_q, mem_rdata_i};
          rerr_q       <= 1'b0;
          if_rvalid_q  <= !owner_dbg_q;
          dbg_rvalid_q <= owner_dbg_q;
          state_q      <= StIdle;
        end
        StOor: begin
          rdata_q      <= '0;
          rerr_q       <= 1'b1;
          if_rvalid_q  <= !owner_dbg_q;
          dbg_rvalid_q <= owner_dbg_q;
          state_q      <= StIdle;
        end
        default: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: byte memory model, directed scenarios and randomized reads
// checked against a word-level reference computed from the memory array.
module tb_imem_fetch_arbiter;
  localparam int unsigned MemBytes = 1024;
  localparam int unsigned Aw       = 10;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  imem_fetch_arbiter_if bus ();
  logic          busy;
  logic          mem_rd_en;
  logic [Aw-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem [MemBytes];

  int checks = 0;
  int errors = 0;

  imem_fetch_arbiter #(.MEM_BYTES(MemBytes), .AW(Aw)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .busy_o      (busy),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata)
  );

  // Synchronous byte memory, one-cycle read latency.
  always_ff @(posedge clk_i) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Reference: big-endian word of four wrapping bytes, or zero when out of range.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int unsigned b;
    b = a;
    if (b >= MemBytes) return 32'h0;
    return {mem[b % MemBytes], mem[(b + 1) % MemBytes], mem[(b + 2) % MemBytes],
            mem[(b + 3) % MemBytes]};
  endfunction

  // Drops requests after the grant edge and records what comes back.
  task automatic collect(input bit dbg, output int lat, output logic [31:0] rd, output logic er,
                         output logic [15:0] en_mask, output logic [3:0][Aw-1:0] ma,
                         output bit own_err);
    lat = -1; rd = '0; er = 1'b0; en_mask = '0; ma = '0; own_err = 1'b0;
    @(posedge clk_i); #1;
    bus.if_req  = 1'b0;
    bus.dbg_req = 1'b0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk_i);
      if (mem_rd_en === 1'b1) begin
        en_mask[c] = 1'b1;
        if (c <= 4) ma[c-1] = mem_addr;
      end
      if (bus.if_rvalid === 1'b1 || bus.dbg_rvalid === 1'b1) begin
        lat     = c;
        rd      = bus.rdata;
        er      = bus.rerr;
        own_err = (bus.if_rvalid === dbg) || (bus.dbg_rvalid !== dbg);
        break;
      end
    end
  endtask

  // Issues one request from an idle bus and gathers its response.
  task automatic run_txn(input bit dbg, input logic [31:0] addr, output bit got, output int lat,
                         output logic [31:0] rd, output logic er, output logic [15:0] en_mask,
                         output logic [3:0][Aw-1:0] ma, output bit own_err);
    got = 1'b0;
    @(negedge clk_i);
    if (dbg) begin bus.dbg_req = 1'b1; bus.dbg_addr = addr; end
    else begin bus.if_req = 1'b1; bus.if_addr = addr; end
    #1;
    for (int n = 0; n < 40; n++) begin
      if (dbg ? bus.dbg_gnt : bus.if_gnt) begin got = 1'b1; break; end
      @(negedge clk_i); #1;
    end
    collect(dbg, lat, rd, er, en_mask, ma, own_err);
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0; bus.dbg_req = 1'b1; bus.dbg_addr = 32'h0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({bus.if_gnt, bus.dbg_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b want 00", {bus.if_gnt, bus.dbg_gnt});
    end
    checks++;
    if ({busy, mem_rd_en, mem_addr, bus.if_rvalid, bus.dbg_rvalid, bus.rerr} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b rd_en=%b addr=%0d rv=%b%b rerr=%b want all 0",
               busy, mem_rd_en, mem_addr, bus.if_rvalid, bus.dbg_rvalid, bus.rerr);
    end
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 00000000", bus.rdata);
    end
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_directed();
    bit got; int lat; logic [31:0] rd; logic er; logic [15:0] em; logic [3:0][Aw-1:0] ma;
    bit oe;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    mem[8] = 8'h00;
    run_txn(1'b0, 32'd0, got, lat, rd, er, em, ma, oe);
    checks++;
    if (!got || lat != 6) begin
      errors++; $display("FAIL dir0_latency: gnt=%0b lat=%0d want gnt=1 lat=6", got, lat);
    end
    checks++;
    if (rd !== 32'h11223344 || er !== 1'b0 || oe) begin
      errors++; $display("FAIL dir0_data: got %h rerr=%b own_err=%0b want 11223344 0 0",
                         rd, er, oe);
    end
    checks++;
    if (em !== 16'h001E || ma !== {10'd3, 10'd2, 10'd1, 10'd0}) begin
      errors++; $display("FAIL dir0_mem: mask=%h addrs=%h want 001e 0,1,2,3", em, ma);
    end
    run_txn(1'b0, 32'd5, got, lat, rd, er, em, ma, oe);
    checks++;
    if (rd !== 32'h66778800 || er !== 1'b0 || lat != 6) begin
      errors++; $display("FAIL dir5_data: got %h rerr=%b lat=%0d want 66778800 0 6", rd, er, lat);
    end
  endtask

  task automatic test_wrap();
    bit got; int lat; logic [31:0] rd; logic er; logic [15:0] em; logic [3:0][Aw-1:0] ma;
    bit oe;
    mem[1022] = 8'hAA; mem[1023] = 8'hBB; mem[0] = 8'h11; mem[1] = 8'h22;
    run_txn(1'b1, 32'd1022, got, lat, rd, er, em, ma, oe);
    checks++;
    if (ma !== {10'd1, 10'd0, 10'd1023, 10'd1022} || em !== 16'h001E) begin
      errors++; $display("FAIL wrap_addrs: got %h mask=%h want 1022,1023,0,1", ma, em);
    end
    checks++;
    if (rd !== 32'hAABB1122 || er !== 1'b0 || oe || lat != 6) begin
      errors++; $display("FAIL wrap_data: got %h rerr=%b own_err=%0b lat=%0d want aabb1122",
                         rd, er, oe, lat);
    end
  endtask

  task automatic test_oor();
    bit got; int lat; logic [31:0] rd; logic er; logic [15:0] em; logic [3:0][Aw-1:0] ma;
    bit oe;
    run_txn(1'b0, 32'h0000_0400, got, lat, rd, er, em, ma, oe);
    checks++;
    if (!got || lat != 2 || em !== 16'h0) begin
      errors++; $display("FAIL oor_timing: gnt=%0b lat=%0d mask=%h want 1 2 0000", got, lat, em);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || oe) begin
      errors++; $display("FAIL oor_data: got %h rerr=%b own_err=%0b want 0 1 0", rd, er, oe);
    end
    run_txn(1'b0, 32'd2, got, lat, rd, er, em, ma, oe);
    checks++;
    if (er !== 1'b0 || rd !== exp_word(32'd2) || lat != 6) begin
      errors++; $display("FAIL oor_recover: got %h rerr=%b want %h 0", rd, er, exp_word(32'd2));
    end
  endtask

  task automatic test_round_robin();
    int g_cyc[$]; bit g_own[$]; int v_cyc[$]; bit v_own[$]; logic [31:0] v_dat[$];
    logic [31:0] a_if, a_dbg;
    bit both;
    both  = 1'b0;
    a_if  = $urandom_range(0, MemBytes - 1);
    a_dbg = $urandom_range(0, MemBytes - 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = a_if; bus.dbg_req = 1'b1; bus.dbg_addr = a_dbg;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk_i);
      if (c == 24) begin bus.if_req = 1'b0; bus.dbg_req = 1'b0; end
      #1;
      if (bus.if_gnt === 1'b1)  begin g_cyc.push_back(c); g_own.push_back(1'b0); end
      if (bus.dbg_gnt === 1'b1) begin g_cyc.push_back(c); g_own.push_back(1'b1); end
      if (bus.if_rvalid === 1'b1 && bus.dbg_rvalid === 1'b1) both = 1'b1;
      if (bus.if_rvalid === 1'b1 || bus.dbg_rvalid === 1'b1) begin
        v_cyc.push_back(c); v_own.push_back(bus.dbg_rvalid === 1'b1); v_dat.push_back(bus.rdata);
      end
    end
    checks++;
    if (g_cyc.size() != 4 || v_cyc.size() != 4 || both) begin
      errors++; $display("FAIL rr_counts: grants=%0d rvalids=%0d both=%0b want 4 4 0",
                         g_cyc.size(), v_cyc.size(), both);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g_own[k] != k[0] || g_cyc[k] != 6 * k) begin
          errors++; $display("FAIL rr_grant[%0d]: owner=%0d cyc=%0d want %0d %0d",
                             k, g_own[k], g_cyc[k], k % 2, 6 * k);
        end
        checks++;
        if (v_own[k] != k[0] || v_cyc[k] != 6 * k + 6 ||
            v_dat[k] !== exp_word(k[0] ? a_dbg : a_if)) begin
          errors++; $display("FAIL rr_rvalid[%0d]: owner=%0d cyc=%0d data=%h want %0d %0d %h",
                             k, v_own[k], v_cyc[k], v_dat[k], k % 2, 6 * k + 6,
                             exp_word(k[0] ? a_dbg : a_if));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; logic [15:0] em; logic [3:0][Aw-1:0] ma; bit oe;
    bit seen;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    @(negedge clk_i);
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", bus.if_gnt); end
    @(posedge clk_i); #1;
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 10'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_rd2: rd_en=%b addr=%0d busy=%b want 1 2 1",
                         mem_rd_en, mem_addr, busy);
    end
    rst_ni = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'd4;
    #1;
    checks++;
    if ({busy, mem_rd_en, mem_addr, bus.rdata, bus.rerr, bus.if_rvalid, bus.dbg_rvalid,
         bus.if_gnt, bus.dbg_gnt} !== '0) begin
      errors++; $display("FAIL rmid_async: busy=%b rd_en=%b addr=%0d rdata=%h rerr=%b gnt=%b want 0",
                         busy, mem_rd_en, mem_addr, bus.rdata, bus.rerr, bus.if_gnt);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i); #1;
      if (bus.if_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0 || bus.if_gnt !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rmid_quiet: got activity=1 want 0"); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_regnt: got %b want 1", bus.if_gnt); end
    collect(1'b0, lat, rd, er, em, ma, oe);
    checks++;
    if (lat != 6 || rd !== exp_word(32'd4) || er !== 1'b0 || oe || em !== 16'h001E) begin
      errors++; $display("FAIL rmid_read: lat=%0d data=%h rerr=%b mask=%h want 6 %h 0 001e",
                         lat, rd, er, em, exp_word(32'd4));
    end
  endtask

  task automatic test_dbg_drop();
    int dg, dv, ic; logic [31:0] idata;
    dg = 0; dv = 0; ic = -1; idata = '0;
    @(negedge clk_i);
    bus.if_req = 1'b1; bus.if_addr = 32'd6;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL drop_ifgnt: got %b want 1", bus.if_gnt); end
    @(posedge clk_i); #1;
    bus.if_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      if (c == 2) begin bus.dbg_req = 1'b1; bus.dbg_addr = $urandom_range(0, MemBytes - 1); end
      if (c == 4) bus.dbg_req = 1'b0;
      #1;
      if (bus.dbg_gnt === 1'b1) dg++;
      if (bus.dbg_rvalid === 1'b1) dv++;
      if (bus.if_rvalid === 1'b1) begin ic = c; idata = bus.rdata; end
    end
    checks++;
    if (dg != 0 || dv != 0) begin
      errors++; $display("FAIL drop_dbg: gnts=%0d rvalids=%0d want 0 0", dg, dv);
    end
    checks++;
    if (ic != 6 || idata !== exp_word(32'd6)) begin
      errors++; $display("FAIL drop_if: cyc=%0d data=%h want 6 %h", ic, idata, exp_word(32'd6));
    end
  endtask

  task automatic test_random();
    bit got; int lat; logic [31:0] rd; logic er; logic [15:0] em; logic [3:0][Aw-1:0] ma;
    bit oe, dbg, inr; logic [31:0] a; int unsigned b;
    for (int i = 0; i < MemBytes; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 24; k++) begin
      dbg = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0400;
      else a = $urandom_range(0, MemBytes - 1);
      b   = a;
      inr = (b < MemBytes);
      run_txn(dbg, a, got, lat, rd, er, em, ma, oe);
      checks++;
      if (!got || oe || lat != (inr ? 6 : 2)) begin
        errors++; $display("FAIL rand[%0d]_handshake: gnt=%0b own_err=%0b lat=%0d want 1 0 %0d",
                           k, got, oe, lat, inr ? 6 : 2);
      end
      checks++;
      if (rd !== exp_word(a) || er !== !inr) begin
        errors++; $display("FAIL rand[%0d]_data addr=%h: got %h rerr=%b want %h %b",
                           k, a, rd, er, exp_word(a), !inr);
      end
      checks++;
      if (em !== (inr ? 16'h001E : 16'h0000)) begin
        errors++; $display("FAIL rand[%0d]_rden: got mask %h want %h", k, em,
                           inr ? 16'h001E : 16'h0000);
      end
      if (inr) begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (ma[i] !== Aw'((b + i) % MemBytes)) begin
            errors++; $display("FAIL rand[%0d]_addr%0d: got %0d want %0d", k, i, ma[i],
                               (b + i) % MemBytes);
          end
        end
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dbg_req = 1'b0; bus.dbg_addr = '0;
    for (int i = 0; i < MemBytes; i++) mem[i] = 8'h00;
    test_reset();
    test_directed();
    test_wrap();
    test_oor();
    test_round_robin();
    test_reset_mid();
    test_dbg_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Sequences and shares the byte-wide read port of the instruction memory between two requesters: the core's instruction fetch (IF) and the debug/loader port (DBG). Each granted request reads four consecutive bytes over four cycles and returns them as one big-endian 32-bit word (byte at the lowest address in bits 31:24). The block sits between the fetch stage, the debug port and a synchronous byte-read memory with one-cycle read latency.

## Interface
- MEM_BYTES, 1024: memory size in bytes; power of two.
- AW, 10: memory address width, log2(MEM_BYTES).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF request; held until if_gnt or withdrawn.
- if_addr  in  32  IF byte address; any alignment.
- if_gnt  out  1  combinational; IF request accepted this cycle.
- if_rvalid  out  1  registered one-cycle pulse; rdata/rerr belong to IF.
- dbg_req, dbg_addr, dbg_gnt, dbg_rvalid: same as IF set, for DBG.
- rdata  out  32  returned word, shared by both requesters.
- rerr  out  1  out-of-range flag, valid with either rvalid.
- busy  out  1  high when state is not IDLE.
- mem_rd_en  out  1  byte read strobe.
- mem_addr  out  AW  byte address to memory.
- mem_rdata  in  8  byte read data, valid the cycle after mem_rd_en.

## Operation
- States: IDLE, RD0, RD1, RD2, RD3, LAST, OOR.
- IDLE: grant when any req is high. One requester only: grant it. Both: grant the one not granted last (round-robin). After reset, "last granted" = DBG, so IF wins the first tie.
- On grant: latch address and owner. If addr[31:AW] == 0, go to RD0; else go to OOR.
- RDk (k=0..3): mem_rd_en=1, mem_addr=(base+k) mod MEM_BYTES. Wrap-around is required: base 1022 reads 1022, 1023, 0, 1.
- RD1..RD3 and LAST capture mem_rdata as byte k-1 into the assembly register. Byte 0 goes to bits 31:24.
- LAST: capture byte 3, load rdata, pulse the owner's rvalid with rerr=0, go to IDLE.
- OOR: no memory access. Load rdata=0, pulse the owner's rvalid with rerr=1, go to IDLE.
- gnt is asserted only in IDLE and only to the selected requester. A requester that drops req before its grant is never served.
- rvalid pulses are exclusive: only the owner's rvalid fires.
- Reset, including mid-transaction: state=IDLE, last=DBG, all outputs 0 (rdata=0, rerr=0, rvalid=0, mem_rd_en=0, mem_addr=0, busy=0). The in-flight word is discarded and no rvalid is produced.

## Timing
- Grant cycle C0 (IDLE, gnt=1). RD0..RD3 occupy C1..C4, LAST is C5, rvalid and rdata appear in C6.
- In-range latency: 6 cycles from grant to rvalid.
- Out-of-range: OOR in C1, rvalid with rerr=1 in C2.
- C6 is IDLE, so a new grant may occur in the same cycle as the previous rvalid. Sustained throughput is one word per 6 cycles.
- rdata and rerr hold their value until the next LAST or OOR load. rvalid is high for exactly one cycle.
- mem_rd_en is high only in RD0..RD3, four consecutive cycles per in-range transaction.

## Test plan
- Memory bytes 0..7 = 0x11..0x88, IF reads addr 0: if_gnt in C0, mem_addr 0,1,2,3 in C1..C4, if_rvalid in C6 with rdata=0x11223344 and rerr=0. Repeat at addr 5 (misaligned): rdata=0x66778800, with byte 8 = 0x00.
- Wrap: bytes 1022,1023,0,1 = 0xAA,0xBB,0x11,0x22, DBG reads addr 1022: mem_addr sequence 1022, 1023, 0, 1, dbg_rvalid with rdata=0xAABB1122.
- Both requesters held high continuously from reset: grants alternate IF, DBG, IF, DBG every 6 cycles, each rvalid goes only to its owner, and the first grant is IF.
- IF addr 0x00000400: OOR path, no mem_rd_en, if_rvalid in C2 with rdata=0 and rerr=1. The next in-range read returns rerr=0.
- Reset asserted during RD2: all outputs 0 asynchronously and no rvalid. After release with if_req high, the grant comes the next cycle and a full 6-cycle read completes correctly.
- DBG raises req and drops it while an IF transaction is busy: no dbg_gnt and no dbg_rvalid.
